core_reg_file_mp: RTL and testbench
===================================

// Module: core_reg_file_mp
// PURPOSE
//  Parametrised multi-port integer register file for the core EXEC/WB path.
//  Provides NRD combinational read ports and NWR synchronous write ports.
//  Optional same-cycle write->read bypass. Per-register busy scoreboard,
//  set at issue and cleared at write-back, lets EXEC detect pending hazards.
//  Reset clears all registers and busy bits; register 0 is hardwired to zero.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  number of architectural registers (power of 2, >=2)
//  NRD      2   number of read ports (>=1)
//  NWR      1   number of write ports (>=1)
//  BYPASS   1   1: same-cycle write data forwarded to reads; 0: no forwarding
//  ID_W     $clog2(NREGS) localparam, register index width
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  rd_id      in   NRD*ID_W   read index, port p at [p*ID_W +: ID_W]
//  rd_value   out  NRD*XLEN   read data, port p at [p*XLEN +: XLEN]
//  rd_busy    out  NRD        1: register read on port p has a pending writer
//  wr_en      in   NWR        write enable per write port
//  wr_id      in   NWR*ID_W   write index per write port
//  wr_value   in   NWR*XLEN   write data per write port
//  iss_en     in   1          issue: mark iss_id busy (instruction with rd dispatched)
//  iss_id     in   ID_W       destination register of issued instruction
//  flush      in   1          clear all busy bits (pipeline flush)
// BEHAVIOUR
//  Reset: rst_n low -> all NREGS registers = 0, all busy bits = 0, immediately
//   (async assert); outputs then read 0 with rd_busy = 0. Release is sync to clk.
//  Register 0: writes ignored, busy never set, reads always 0, rd_busy always 0.
//  Write: on rising edge, for each port w with wr_en[w] and wr_id[w]!=0,
//   reg[wr_id[w]] <= wr_value[w]. Same index on several ports in one cycle:
//   highest-numbered port wins.
//  Read: combinational, zero latency. BYPASS=1: if any enabled write port
//   targets rd_id[p] (!=0) this cycle, rd_value[p] = that wr_value (highest
//   port wins), else stored value. BYPASS=0: always stored value (new data
//   visible the cycle after the write edge).
//  Scoreboard busy[NREGS] bits, updated on rising edge, priority high->low:
//   1. flush=1: all busy <= 0 (iss_en ignored that cycle; writes still occur)
//   2. iss_en=1 and iss_id!=0: busy[iss_id] <= 1, even if written this cycle
//      (new producer supersedes old)
//   3. any enabled write to index i (i!=0, not set by 2): busy[i] <= 0
//  rd_busy[p] = busy[rd_id[p]] & ~(BYPASS & enabled write to rd_id[p] this
//   cycle) & (rd_id[p]!=0). Same-cycle iss_en does not affect rd_busy (takes
//   effect next cycle).
//  Write to non-busy register permitted; updates data, busy stays 0.
//  No internal counters wrap; ID_W covers all indices exactly.
// TESTING
//  1. Reset with rst_n=0 mid-run after writes -> all rd_value=0, rd_busy=0
//     asynchronously, before next clk edge.
//  2. wr_en=1 wr_id=5 wr_value=32'hDEADBEEF, rd_id[0]=5 same cycle -> BYPASS=1:
//     rd_value[0]=DEADBEEF that cycle; BYPASS=0: old value, DEADBEEF next cycle.
//  3. Write wr_id=0 value 32'hFFFFFFFF, iss_en iss_id=0 -> reg0 reads 0, rd_busy=0.
//  4. iss_en iss_id=7 -> next cycle rd_busy=1 for id 7; write id 7 -> same
//     cycle rd_busy=0 (BYPASS=1), busy bit clear after edge.
//  5. iss_en iss_id=9 and write id 9 same cycle -> busy[9]=1 next cycle;
//     flush with iss_en iss_id=3 -> all busy=0, busy[3]=0.
//  6. NWR=2: both ports write id 4 (0x11, 0x22) -> reg4=0x22; read bypass 0x22.

Source files
------------

// File: rtl/core_reg_file_mp.sv
// Multi-port integer register file with optional write->read bypass and a
// per-register busy scoreboard for hazard detection in EXEC.
module core_reg_file_mp #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  bit BYPASS = 1'b1,
  localparam int ID_W   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*ID_W-1:0]  rd_id,
  output logic [NRD*XLEN-1:0]  rd_value,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*ID_W-1:0]  wr_id,
  input  logic [NWR*XLEN-1:0]  wr_value,
  input  logic                 iss_en,
  input  logic [ID_W-1:0]      iss_id,
  input  logic                 flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Ascending port order lets the last non-blocking assignment (highest port) win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_id[w*ID_W +: ID_W] != '0))
          regs[wr_id[w*ID_W +: ID_W]] <= wr_value[w*XLEN +: XLEN];
      end
    end
  end

  // Issue is applied after the write-back clears so a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_id[w*ID_W +: ID_W] != '0))
          busy[wr_id[w*ID_W +: ID_W]] <= 1'b0;
      end
      if (iss_en && (iss_id != '0))
        busy[iss_id] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] val;
    logic            hit;

    assign id = rd_id[p*ID_W +: ID_W];

    always_comb begin
      val = regs[id];
      hit = 1'b0;
      if (BYPASS) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_id[w*ID_W +: ID_W] == id)) begin
            val = wr_value[w*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
      end
      if (id == '0) val = '0;
    end

    assign rd_value[p*XLEN +: XLEN] = val;
    assign rd_busy[p] = busy[id] & ~hit & (id != '0);
  end

endmodule

// File: tb/tb_core_reg_file_mp.sv
// Directed bench for core_reg_file_mp: a bypassing dual-write instance and a
// non-bypassing single-write instance driven with the same stimulus.
module tb_core_reg_file_mp;
  localparam int XLEN = 32;
  localparam int ID_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2*ID_W-1:0]    rd_id;
  logic [2*XLEN-1:0]    rd_value;
  logic [1:0]           rd_busy;
  logic [1:0]           wr_en;
  logic [2*ID_W-1:0]    wr_id;
  logic [2*XLEN-1:0]    wr_value;
  logic                 iss_en;
  logic [ID_W-1:0]      iss_id;
  logic                 flush;
  logic [2*XLEN-1:0]    nb_rd_value;
  logic [1:0]           nb_rd_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_reg_file_mp #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_id(rd_id), .rd_value(rd_value), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_id(wr_id), .wr_value(wr_value),
    .iss_en(iss_en), .iss_id(iss_id), .flush(flush)
  );

  core_reg_file_mp #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_id(rd_id), .rd_value(nb_rd_value), .rd_busy(nb_rd_busy),
    .wr_en(wr_en[0]), .wr_id(wr_id[ID_W-1:0]), .wr_value(wr_value[XLEN-1:0]),
    .iss_en(iss_en), .iss_id(iss_id), .flush(flush)
  );

  task automatic idle();
    wr_en = '0; wr_id = '0; wr_value = '0;
    iss_en = 1'b0; iss_id = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd_id = {5'd0, 5'd3};
    #1;
    n_tests++;
    if (rd_value !== '0) begin
      n_fail++; $display("FAIL reset_value: got %h exp 0", rd_value);
    end
    n_tests++;
    if (rd_busy !== 2'b00 || nb_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b exp 00/00", rd_busy, nb_rd_busy);
    end
  endtask

  task automatic test_write_bypass();
    idle();
    wr_en = 2'b01; wr_id = {5'd0, 5'd5}; wr_value = {32'h0, 32'hDEADBEEF};
    rd_id = {5'd0, 5'd5};
    #1;
    n_tests++;
    if (rd_value[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h exp deadbeef", rd_value[31:0]);
    end
    n_tests++;
    if (nb_rd_value[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %h exp 0", nb_rd_value[31:0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_value[31:0] !== 32'hDEADBEEF || nb_rd_value[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stored_after_edge: got %h/%h exp deadbeef", rd_value[31:0], nb_rd_value[31:0]);
    end
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL nonbusy_write_busy: got %b exp 0", rd_busy[0]);
    end
  endtask

  task automatic test_reg0();
    idle();
    wr_en = 2'b01; wr_id = {5'd0, 5'd0}; wr_value = {32'h0, 32'hFFFFFFFF};
    iss_en = 1'b1; iss_id = 5'd0;
    rd_id = {5'd0, 5'd0};
    #1;
    n_tests++;
    if (rd_value[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL reg0_same_cycle: got %h busy %b exp 0 busy 0", rd_value[31:0], rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_value[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || nb_rd_value[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL reg0_after_edge: got %h/%h busy %b exp 0 busy 0", rd_value[31:0], nb_rd_value[31:0], rd_busy[0]);
    end
  endtask

  task automatic test_busy();
    idle();
    iss_en = 1'b1; iss_id = 5'd7;
    rd_id = {5'd0, 5'd7};
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL issue_same_cycle_busy: got %b exp 0", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1 || nb_rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_issue: got %b/%b exp 1/1", rd_busy[0], nb_rd_busy[0]);
    end
    wr_en = 2'b01; wr_id = {5'd0, 5'd7}; wr_value = {32'h0, 32'h77};
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0 || rd_value[31:0] !== 32'h77) begin
      n_fail++; $display("FAIL writeback_bypass: got busy %b val %h exp busy 0 val 77", rd_busy[0], rd_value[31:0]);
    end
    n_tests++;
    if (nb_rd_busy[0] !== 1'b1 || nb_rd_value[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL writeback_nobypass: got busy %b val %h exp busy 1 val 0", nb_rd_busy[0], nb_rd_value[31:0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0 || nb_rd_busy[0] !== 1'b0 || nb_rd_value[31:0] !== 32'h77) begin
      n_fail++; $display("FAIL busy_cleared: got busy %b/%b val %h exp 0/0 val 77", rd_busy[0], nb_rd_busy[0], nb_rd_value[31:0]);
    end
  endtask

  task automatic test_issue_and_flush();
    idle();
    iss_en = 1'b1; iss_id = 5'd9;
    wr_en = 2'b01; wr_id = {5'd0, 5'd9}; wr_value = {32'h0, 32'h99};
    rd_id = {5'd3, 5'd9};
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1 || rd_value[31:0] !== 32'h99) begin
      n_fail++; $display("FAIL issue_beats_writeback: got busy %b val %h exp busy 1 val 99", rd_busy[0], rd_value[31:0]);
    end
    flush = 1'b1; iss_en = 1'b1; iss_id = 5'd3;
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy !== 2'b00 || nb_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_clears: got %b/%b exp 00/00", rd_busy, nb_rd_busy);
    end
  endtask

  task automatic test_dual_write();
    idle();
    wr_en = 2'b11; wr_id = {5'd4, 5'd4}; wr_value = {32'h22, 32'h11};
    rd_id = {5'd4, 5'd0};
    #1;
    n_tests++;
    if (rd_value[63:32] !== 32'h22) begin
      n_fail++; $display("FAIL dual_write_bypass: got %h exp 22", rd_value[63:32]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_value[63:32] !== 32'h22) begin
      n_fail++; $display("FAIL dual_write_stored: got %h exp 22", rd_value[63:32]);
    end
    n_tests++;
    if (nb_rd_value[63:32] !== 32'h11) begin
      n_fail++; $display("FAIL single_port_stored: got %h exp 11", nb_rd_value[63:32]);
    end
  endtask

  task automatic test_async_reset();
    idle();
    iss_en = 1'b1; iss_id = 5'd12;
    tick();
    idle();
    rd_id = {5'd12, 5'd5};
    #1;
    n_tests++;
    if (rd_busy[1] !== 1'b1 || rd_value[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL pre_reset_state: got busy %b val %h exp busy 1 val deadbeef", rd_busy[1], rd_value[31:0]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rd_value !== '0 || nb_rd_value !== '0) begin
      n_fail++; $display("FAIL async_reset_value: got %h/%h exp 0", rd_value, nb_rd_value);
    end
    n_tests++;
    if (rd_busy !== 2'b00 || nb_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL async_reset_busy: got %b/%b exp 00/00", rd_busy, nb_rd_busy);
    end
    tick();
    rst_n = 1'b1;
    rd_id = {5'd4, 5'd7};
    #1;
    n_tests++;
    if (rd_value !== '0) begin
      n_fail++; $display("FAIL post_reset_value: got %h exp 0", rd_value);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_id = '0;
    idle();
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_write_bypass();
    test_reg0();
    test_busy();
    test_issue_and_flush();
    test_dual_write();
    test_async_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
